// File: rtl/sar_adc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_ctrl_if
// Brief    : Handshake and DAC/comparator bundle for the SAR controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sar_adc_ctrl_if #(
    parameter int NBITS = 3
);
    logic             start;
    logic             add;
    logic [NBITS-1:0] sel_wire;
    logic             sample;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] result;

    modport master (
        input  start,
        input  add,
        output sel_wire,
        output sample,
        output busy,
        output done,
        output result
    );

    modport slave (
        output start,
        output add,
        input  sel_wire,
        input  sample,
        input  busy,
        input  done,
        input  result
    );
endinterface
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_ctrl
// Brief    : Parametrised MSB-first successive-approximation controller with
//            start/busy/done handshake. Define SAR_CONT_EN for free-running mode.
// Revision : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl #(
    parameter int NBITS      = 3,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE_CYC = 1
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    sar_adc_ctrl_if.master bus
);

    localparam int c_CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_BIT_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [c_CNT_W-1:0] c_SAMPLE_LOAD = c_CNT_W'(SAMPLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_BIT_W-1:0] c_MSB         = c_BIT_W'(NBITS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE     = c_BIT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_BIT_W-1:0] r_bit;
    logic [c_BIT_W-1:0] w_bit_nxt;
    logic [NBITS-1:0]   r_code;
    logic [NBITS-1:0]   w_code_nxt;
    logic [NBITS-1:0]   r_result;
    logic [NBITS-1:0]   w_result_nxt;
    logic [NBITS-1:0]   w_resolved;
    logic [NBITS-1:0]   w_sel;
    logic               w_sample;
    logic               w_busy;
    logic               w_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_code   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_code   <= w_code_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_code_nxt   = r_code;
        w_result_nxt = r_result;
        // Trial bit already set in r_code, so the comparator decides keep/clear.
        w_resolved        = r_code;
        w_resolved[r_bit] = bus.add;

        w_sample = (r_state == S_SAMPLE);
        w_busy   = (r_state != S_IDLE);
        w_done   = (r_state == S_DONE);
        w_sel    = (r_state == S_CONVERT) ? r_code : '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SAMPLE;
                    w_cnt_nxt   = c_SAMPLE_LOAD;
                end
            end
            S_SAMPLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt           = S_CONVERT;
                    w_cnt_nxt             = c_SETTLE_LOAD;
                    w_bit_nxt             = c_MSB;
                    w_code_nxt            = '0;
                    w_code_nxt[NBITS-1]   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            S_CONVERT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else if (r_bit == '0) begin
                    w_state_nxt  = S_DONE;
                    w_code_nxt   = w_resolved;
                    w_result_nxt = w_resolved;
                end else begin
                    w_cnt_nxt                      = c_SETTLE_LOAD;
                    w_bit_nxt                      = r_bit - c_BIT_ONE;
                    w_code_nxt                     = w_resolved;
                    w_code_nxt[r_bit - c_BIT_ONE]  = 1'b1;
                end
            end
            S_DONE: begin
`ifdef SAR_CONT_EN
                w_state_nxt = S_SAMPLE;
                w_cnt_nxt   = c_SAMPLE_LOAD;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.sel_wire = w_sel;
    assign bus.sample   = w_sample;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_ctrl
// Brief    : Self-checking bench for sar_adc_ctrl (3-bit and 8-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vin3 = 0;
    int   vin8 = 0;
    logic start3 = 1'b0;
    logic start8 = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sar_adc_ctrl_if #(.NBITS(3)) bus3 ();
    sar_adc_ctrl_if #(.NBITS(8)) bus8 ();

    // Ideal comparator: keep the trial bit when the input is at or above the DAC code
    assign bus3.start = start3;
    assign bus8.start = start8;
    assign bus3.add   = (vin3 >= int'(bus3.sel_wire));
    assign bus8.add   = (vin8 >= int'(bus8.sel_wire));

    sar_adc_ctrl #(.NBITS(3), .SAMPLE_CYC(2), .SETTLE_CYC(1)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3)
    );
    sar_adc_ctrl #(.NBITS(8), .SAMPLE_CYC(2), .SETTLE_CYC(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8)
    );

    task automatic snap(input bit big, output logic [7:0] sel, output logic [7:0] res,
                        output logic smp, output logic bsy, output logic dn);
        if (big) begin
            sel = bus8.sel_wire; res = bus8.result;
            smp = bus8.sample;   bsy = bus8.busy;   dn = bus8.done;
        end else begin
            sel = {5'b0, bus3.sel_wire}; res = {5'b0, bus3.result};
            smp = bus3.sample;           bsy = bus3.busy;           dn = bus3.done;
        end
    endtask

    // One full conversion, checked cycle by cycle against the textbook SAR search
    task automatic do_conv(input bit big, input int vin);
        int n = big ? 8 : 3;
        int s = 2;
        int t = big ? 3 : 1;
        int lat = 1 + s + n * t;
        int trials[$];
        int kept = 0;
        logic [7:0] sel, res, exp_sel;
        logic smp, bsy, dn;
        for (int i = n - 1; i >= 0; i--) begin
            int tr = kept | (1 << i);
            trials.push_back(tr);
            if (vin >= tr) kept = tr;
        end
        @(negedge clk);
        if (big) begin vin8 = vin; start8 = 1'b1; end
        else     begin vin3 = vin; start3 = 1'b1; end
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            start3 = 1'b0; start8 = 1'b0;
            snap(big, sel, res, smp, bsy, dn);
            exp_sel = (k > s && k <= s + n * t) ? 8'(trials[(k - s - 1) / t]) : 8'd0;
            n_checks++;
            if (bsy !== (k <= lat))
                $display("FAIL busy n=%0d vin=%0d cyc=%0d: got %b expected %b", n, vin, k, bsy, (k <= lat));
            else n_pass++;
            n_checks++;
            if (smp !== (k <= s))
                $display("FAIL sample n=%0d vin=%0d cyc=%0d: got %b expected %b", n, vin, k, smp, (k <= s));
            else n_pass++;
            n_checks++;
            if (dn !== (k == lat))
                $display("FAIL done n=%0d vin=%0d cyc=%0d: got %b expected %b", n, vin, k, dn, (k == lat));
            else n_pass++;
            if (k != lat) begin
                n_checks++;
                if (sel !== exp_sel)
                    $display("FAIL sel_wire n=%0d vin=%0d cyc=%0d: got %0d expected %0d", n, vin, k, sel, exp_sel);
                else n_pass++;
            end
            if (k >= lat) begin
                n_checks++;
                if (res !== 8'(vin))
                    $display("FAIL result n=%0d vin=%0d cyc=%0d: got %0d expected %0d", n, vin, k, res, vin);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] sel, res;
        logic smp, bsy, dn;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            snap(b[0], sel, res, smp, bsy, dn);
            n_checks++;
            if ({sel, res, smp, bsy, dn} !== 19'd0)
                $display("FAIL reset_state dut%0d: got sel=%0d res=%0d s/b/d=%b%b%b expected all zero", b, sel, res, smp, bsy, dn);
            else n_pass++;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        do_conv(0, 5);
    endtask

    task automatic test_boundaries();
        do_conv(0, 0);
        do_conv(0, 7);
        do_conv(1, 0);
        do_conv(1, 255);
    endtask

    task automatic test_random();
        repeat (12) do_conv(0, int'($urandom_range(0, 7)));
        repeat (6)  do_conv(1, int'($urandom_range(0, 255)));
    endtask

    task automatic test_abort();
        logic [7:0] sel, res;
        logic smp, bsy, dn;
        int dones = 0;
        do_conv(0, 5);
        @(negedge clk);
        vin3 = 6; start3 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start3 = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        snap(0, sel, res, smp, bsy, dn);
        n_checks++;
        if (sel !== 8'd0) $display("FAIL abort_sel: got %0d expected 0", sel); else n_pass++;
        n_checks++;
        if (bsy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bsy); else n_pass++;
        n_checks++;
        if (res !== 8'd0) $display("FAIL abort_result: got %0d expected 0", res); else n_pass++;
        n_checks++;
        if ({smp, dn} !== 2'b00) $display("FAIL abort_sample_done: got %b expected 00", {smp, dn}); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            snap(0, sel, res, smp, bsy, dn);
            if (dn === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", dones); else n_pass++;
        n_checks++;
        if (res !== 8'd0) $display("FAIL abort_result_held: got %0d expected 0", res); else n_pass++;
        do_conv(0, 6);
    endtask

    task automatic test_start_ignored();
        logic [7:0] sel, res;
        logic smp, bsy, dn;
        int dones = 0;
        int done_cyc = -1;
        @(negedge clk);
        vin3 = 3; start3 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start3 = (k == 3 || k == 4);
            snap(0, sel, res, smp, bsy, dn);
            if (dn === 1'b1) begin dones++; done_cyc = k; end
        end
        n_checks++;
        if (dones != 1) $display("FAIL start_ignored_count: got %0d expected 1", dones); else n_pass++;
        n_checks++;
        if (done_cyc != 6) $display("FAIL start_ignored_cycle: got %0d expected 6", done_cyc); else n_pass++;
        n_checks++;
        if (res !== 8'd3) $display("FAIL start_ignored_result: got %0d expected 3", res); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] sel, res;
        logic smp, bsy, dn;
        int done_cycles[$];
        logic [7:0] res_at[$];
        @(negedge clk);
        vin3 = 2; start3 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 7) vin3 = 4;
            if (k == 8) start3 = 1'b0;
            snap(0, sel, res, smp, bsy, dn);
            if (dn === 1'b1) begin done_cycles.push_back(k); res_at.push_back(res); end
            if (k == 7 || k == 8) begin
                n_checks++;
                if (bsy !== (k == 8))
                    $display("FAIL b2b_busy cyc=%0d: got %b expected %b", k, bsy, (k == 8));
                else n_pass++;
            end
        end
        n_checks++;
        if (done_cycles.size() != 2 || done_cycles[0] != 6 || done_cycles[1] != 13)
            $display("FAIL b2b_done_cycles: got %0d pulses first=%0d expected 2 pulses at 6,13",
                     done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] : -1);
        else n_pass++;
        n_checks++;
        if (res_at.size() != 2 || res_at[0] !== 8'd2 || res_at[1] !== 8'd4)
            $display("FAIL b2b_results: got %0d results expected 2,4", res_at.size());
        else n_pass++;
    endtask

    task automatic test_sweep8();
        for (int v = 0; v < 256; v++) do_conv(1, v);
    endtask

    task automatic test_cont();
        logic [7:0] sel, res;
        logic smp, bsy, dn;
        @(negedge clk);
        vin3 = 3; start3 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            snap(0, sel, res, smp, bsy, dn);
            n_checks++;
            if (bsy !== 1'b1) $display("FAIL cont_busy cyc=%0d: got %b expected 1", k, bsy); else n_pass++;
            n_checks++;
            if (dn !== (k % 6 == 0))
                $display("FAIL cont_done cyc=%0d: got %b expected %b", k, dn, (k % 6 == 0));
            else n_pass++;
            if (k == 6 || k == 12) begin
                n_checks++;
                if (res !== ((k == 6) ? 8'd3 : 8'd6))
                    $display("FAIL cont_result cyc=%0d: got %0d expected %0d", k, res, (k == 6) ? 3 : 6);
                else n_pass++;
                vin3 = 6;
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef SAR_CONT_EN
        test_cont();
`else
        test_basic();
        test_boundaries();
        test_random();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_sweep8();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
